// File: rtl/instruction_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher: address width,
// RISC-V control-flow opcodes and the fetch FSM encoding.
package instruction_fetcher_pkg;

  localparam int RAM_ADR_W = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef logic [RAM_ADR_W-1:0] adr_t;

  typedef enum logic [2:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_DROP,
    ST_JSTALL
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetcher_if.sv
// Bundle of the fetcher's i-cache, predictor, decoder, ROB-training and redirect signals.
interface instruction_fetcher_if;
  import instruction_fetcher_pkg::*;

  logic        ic_req_o;
  adr_t        ic_adr_o;
  logic        ic_valid_i;
  logic [31:0] ic_inst_i;

  adr_t        bp_pc_o;
  logic        bp_br_i;
  logic        bp_en_o;
  logic        bp_abr_o;
  adr_t        bp_tpc_o;

  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_inst_o;
  adr_t        dec_pc_o;
  logic        dec_pred_o;

  logic        rob_br_en_i;
  logic        rob_br_taken_i;
  adr_t        rob_br_pc_i;

  logic        flush_i;
  adr_t        flush_pc_i;

  modport master (
    output ic_req_o, ic_adr_o, bp_pc_o, bp_en_o, bp_abr_o, bp_tpc_o,
    output dec_valid_o, dec_inst_o, dec_pc_o, dec_pred_o,
    input  ic_valid_i, ic_inst_i, bp_br_i, dec_ready_i,
    input  rob_br_en_i, rob_br_taken_i, rob_br_pc_i, flush_i, flush_pc_i
  );

  modport slave (
    input  ic_req_o, ic_adr_o, bp_pc_o, bp_en_o, bp_abr_o, bp_tpc_o,
    input  dec_valid_o, dec_inst_o, dec_pc_o, dec_pred_o,
    output ic_valid_i, ic_inst_i, bp_br_i, dec_ready_i,
    output rob_br_en_i, rob_br_taken_i, rob_br_pc_i, flush_i, flush_pc_i
  );

endinterface

// File: rtl/instruction_fetcher_predecode.sv
// Combinational pre-decode of a returned instruction: classifies control flow,
// extracts B/J immediates and picks the next fetch PC and taken-path flag.
module instruction_fetcher_predecode
  import instruction_fetcher_pkg::*;
(
  input  logic [31:0] inst_i,
  input  adr_t        pc_i,
  input  logic        bp_br_i,
  output logic        is_jalr_o,
  output adr_t        next_pc_o,
  output logic        pred_o
);

  logic signed [RAM_ADR_W-1:0] imm_b;
  logic signed [RAM_ADR_W-1:0] imm_j;

  always_comb begin
    imm_b = {{(RAM_ADR_W-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    imm_j = {{(RAM_ADR_W-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    is_jalr_o = 1'b0;
    pred_o    = 1'b0;
    next_pc_o = pc_i + adr_t'(4);

    case (inst_i[6:0])
      OP_BRANCH: begin
        if (bp_br_i) begin
          next_pc_o = pc_i + adr_t'(imm_b);
          pred_o    = 1'b1;
        end
      end
      OP_JAL: begin
        next_pc_o = pc_i + adr_t'(imm_j);
        pred_o    = 1'b1;
      end
      // Target of a JALR is unknown here; fetch parks until a redirect arrives.
      OP_JALR: begin
        is_jalr_o = 1'b1;
        next_pc_o = pc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the PC, issues one i-cache request at a time, pre-decodes the
// return, hands it to the decoder through a one-entry slot and relays ROB training.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter adr_t RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  instruction_fetcher_if.master bus
);

  fetch_state_e state_q, state_d;
  adr_t         pc_q, pc_d;

  logic         dec_valid_q, dec_valid_d;
  logic         dec_pred_q, dec_pred_d;
  logic [31:0]  dec_inst_q, dec_inst_d;
  adr_t         dec_pc_q, dec_pc_d;

  logic         hold_pred_q, hold_pred_d;
  logic         hold_jalr_q, hold_jalr_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  adr_t         hold_pc_q, hold_pc_d;

  logic         bp_en_q, bp_en_d;
  logic         bp_abr_q, bp_abr_d;
  adr_t         bp_tpc_q, bp_tpc_d;

  logic         pd_is_jalr;
  adr_t         pd_next_pc;
  logic         pd_pred;
  logic         slot_free;

  instruction_fetcher_predecode u_predecode (
    .inst_i    (bus.ic_inst_i),
    .pc_i      (pc_q),
    .bp_br_i   (bus.bp_br_i),
    .is_jalr_o (pd_is_jalr),
    .next_pc_o (pd_next_pc),
    .pred_o    (pd_pred)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_valid_d = dec_valid_q;
    dec_pred_d  = dec_pred_q;
    dec_inst_d  = dec_inst_q;
    dec_pc_d    = dec_pc_q;
    hold_pred_d = hold_pred_q;
    hold_jalr_d = hold_jalr_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    bp_en_d     = bus.rob_br_en_i;
    bp_abr_d    = bus.rob_br_taken_i;
    bp_tpc_d    = bus.rob_br_pc_i;

    slot_free = !dec_valid_q || bus.dec_ready_i;
    if (dec_valid_q && bus.dec_ready_i) dec_valid_d = 1'b0;

    case (state_q)
      ST_ISSUE: begin
        if (slot_free) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.ic_valid_i) begin
          pc_d = pd_next_pc;
          if (slot_free) begin
            dec_valid_d = 1'b1;
            dec_inst_d  = bus.ic_inst_i;
            dec_pc_d    = pc_q;
            dec_pred_d  = pd_pred;
            state_d     = pd_is_jalr ? ST_JSTALL : ST_ISSUE;
          end else begin
            hold_inst_d = bus.ic_inst_i;
            hold_pc_d   = pc_q;
            hold_pred_d = pd_pred;
            hold_jalr_d = pd_is_jalr;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          dec_valid_d = 1'b1;
          dec_inst_d  = hold_inst_q;
          dec_pc_d    = hold_pc_q;
          dec_pred_d  = hold_pred_q;
          state_d     = hold_jalr_q ? ST_JSTALL : ST_ISSUE;
        end
      end
      ST_DROP: begin
        if (bus.ic_valid_i) state_d = ST_ISSUE;
      end
      default: ;
    endcase

    // A redirect still has to swallow a return that is in flight but not yet back.
    if (bus.flush_i) begin
      pc_d        = bus.flush_pc_i;
      dec_valid_d = 1'b0;
      state_d     = ((state_q == ST_WAIT || state_q == ST_DROP) && !bus.ic_valid_i)
                    ? ST_DROP : ST_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ISSUE;
      pc_q        <= RESET_PC;
      dec_valid_q <= 1'b0;
      dec_pred_q  <= 1'b0;
      hold_pred_q <= 1'b0;
      hold_jalr_q <= 1'b0;
      bp_en_q     <= 1'b0;
      bp_abr_q    <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_valid_q <= dec_valid_d;
      dec_pred_q  <= dec_pred_d;
      hold_pred_q <= hold_pred_d;
      hold_jalr_q <= hold_jalr_d;
      bp_en_q     <= bp_en_d;
      bp_abr_q    <= bp_abr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      dec_inst_q  <= dec_inst_d;
      dec_pc_q    <= dec_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      bp_tpc_q    <= bp_tpc_d;
    end
  end

  assign bus.ic_req_o    = (state_q == ST_WAIT) || (state_q == ST_DROP);
  assign bus.ic_adr_o    = pc_q;
  assign bus.bp_pc_o     = pc_q;
  assign bus.dec_valid_o = dec_valid_q;
  assign bus.dec_inst_o  = dec_inst_q;
  assign bus.dec_pc_o    = dec_pc_q;
  assign bus.dec_pred_o  = dec_pred_q;
  assign bus.bp_en_o     = bp_en_q;
  assign bus.bp_abr_o    = bp_abr_q;
  assign bus.bp_tpc_o    = bp_tpc_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Scoreboard bench for instruction_fetcher: a small i-cache model and a decoder
// monitor pop expected requests/instructions pushed by the directed stimulus.
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_BEQ  = 32'hFE000CE3;  // beq x0,x0,-8
  localparam logic [31:0] I_JAL  = 32'h1000006F;  // jal x0,+0x100
  localparam logic [31:0] I_JALR = 32'h00008067;  // jalr x0,0(x1)

  typedef struct {
    logic [31:0] inst;
    adr_t        pc;
    logic        pred;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  instruction_fetcher_if bus();

  instruction_fetcher #(.RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  exp_t exp_dec[$];
  adr_t exp_adr[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat      = 0;
  logic br_first = 1'b1;

  adr_t        p1_pc   [13] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC,
                                32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h120};
  logic [31:0] p1_inst [13] = '{I_ADDI, I_ADDI, I_ADDI, I_ADDI, I_BEQ, I_ADDI, I_ADDI,
                                I_BEQ, I_ADDI, I_ADDI, I_ADDI, I_JAL, I_JALR};
  logic        p1_pred [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // Predictor stand-in: the beq at 0x10 is predicted taken only on its first visit.
  always_comb bus.bp_br_i = br_first && (bus.bp_pc_o == 32'h10);

  function automatic logic [31:0] mem(input adr_t a);
    case (a)
      32'h10:                                      return I_BEQ;
      32'h20:                                      return I_JAL;
      32'h120, 32'h208, 32'h308, 32'h508, 32'h600: return I_JALR;
      default:                                     return I_ADDI;
    endcase
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_dec(input logic [31:0] i, input adr_t pc, input logic pred);
    exp_t e;
    e.inst = i;
    e.pc   = pc;
    e.pred = pred;
    exp_dec.push_back(e);
  endtask

  task automatic flush_to(input adr_t a);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = a;
    step();
    bus.flush_i    = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max);
    int k;
    k = 0;
    while ((exp_dec.size() != 0 || exp_adr.size() != 0) && k < max) begin
      step();
      k++;
    end
    chk(name, 96'(exp_dec.size() + exp_adr.size()), 96'd0);
  endtask

  task automatic check_no_req(input string name, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      step();
      if (bus.ic_req_o) seen = 1'b1;
    end
    chk(name, 96'(seen), 96'd0);
  endtask

  // I-cache model: answers each new request after `lat` idle cycles with a one-cycle pulse.
  initial begin
    logic busy;
    int   cnt;
    adr_t cap_adr;
    busy = 1'b0;
    cnt = 0;
    cap_adr = '0;
    bus.ic_valid_i = 1'b0;
    bus.ic_inst_i  = '0;
    forever begin
      @(negedge clk);
      if (bus.ic_valid_i) begin
        bus.ic_valid_i = 1'b0;
        busy = 1'b0;
        if (cap_adr == 32'h10) br_first = 1'b0;
      end else if (busy) begin
        if (cnt == 0) begin
          bus.ic_valid_i = 1'b1;
          bus.ic_inst_i  = mem(cap_adr);
        end else cnt--;
      end else if (bus.ic_req_o && !rst) begin
        if (exp_adr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL ic_adr: unexpected request at %0h", bus.ic_adr_o);
        end else chk("ic_adr", 96'(bus.ic_adr_o), 96'(exp_adr.pop_front()));
        cap_adr = bus.ic_adr_o;
        busy = 1'b1;
        cnt = lat;
        if (cnt == 0) begin
          bus.ic_valid_i = 1'b1;
          bus.ic_inst_i  = mem(cap_adr);
        end else cnt--;
      end
    end
  end

  // Decoder-side monitor: every completed handshake must match the next expected slot.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && en && bus.dec_valid_o && bus.dec_ready_i) begin
        if (exp_dec.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL dec_slot: unexpected pc %0h inst %0h", bus.dec_pc_o, bus.dec_inst_o);
        end else begin
          e = exp_dec.pop_front();
          chk("dec_slot", {bus.dec_inst_o, bus.dec_pc_o, bus.dec_pred_o}, {e.inst, e.pc, e.pred});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    en  = 1'b1;
    bus.dec_ready_i    = 1'b1;
    bus.rob_br_en_i    = 1'b0;
    bus.rob_br_taken_i = 1'b0;
    bus.rob_br_pc_i    = '0;
    bus.flush_i        = 1'b0;
    bus.flush_pc_i     = '0;
    step(3);

    chk("rst_ic_req",    96'(bus.ic_req_o),    96'd0);
    chk("rst_ic_adr",    96'(bus.ic_adr_o),    96'd0);
    chk("rst_dec_valid", 96'(bus.dec_valid_o), 96'd0);
    chk("rst_dec_pred",  96'(bus.dec_pred_o),  96'd0);
    chk("rst_bp_en",     96'(bus.bp_en_o),     96'd0);

    // Straight-line code, beq taken then not taken, JAL, then JALR parks the fetcher.
    for (int i = 0; i < 13; i++) begin
      exp_adr.push_back(p1_pc[i]);
      push_dec(p1_inst[i], p1_pc[i], p1_pred[i]);
    end
    rst = 1'b0;
    wait_drain("phase_straight_branch_jal", 300);
    check_no_req("jalr_stall_no_req", 4);
    chk("jalr_stall_adr", 96'(bus.ic_adr_o), 96'h120);

    exp_adr.push_back(32'h200);
    exp_adr.push_back(32'h204);
    exp_adr.push_back(32'h208);
    push_dec(I_ADDI, 32'h200, 1'b0);
    push_dec(I_ADDI, 32'h204, 1'b0);
    push_dec(I_JALR, 32'h208, 1'b0);
    flush_to(32'h200);
    wait_drain("phase_flush_from_jstall", 100);
    check_no_req("jstall2_no_req", 3);

    // Redirect while a slow return is outstanding: the old data must be dropped.
    lat = 2;
    exp_adr.push_back(32'h400);
    exp_adr.push_back(32'h300);
    exp_adr.push_back(32'h304);
    exp_adr.push_back(32'h308);
    push_dec(I_ADDI, 32'h300, 1'b0);
    push_dec(I_ADDI, 32'h304, 1'b0);
    push_dec(I_JALR, 32'h308, 1'b0);
    flush_to(32'h400);
    k = 0;
    while (!(bus.ic_req_o && bus.ic_adr_o == 32'h400) && k < 20) begin
      step();
      k++;
    end
    chk("wait_req_400", 96'(k < 20), 96'd1);
    flush_to(32'h300);
    chk("drop_adr", 96'(bus.ic_adr_o), 96'h300);
    chk("drop_dec_valid", 96'(bus.dec_valid_o), 96'd0);
    wait_drain("phase_flush_in_wait", 100);
    lat = 0;
    check_no_req("jstall3_no_req", 3);

    // Decoder stalls for five cycles with one instruction waiting.
    bus.dec_ready_i = 1'b0;
    exp_adr.push_back(32'h500);
    exp_adr.push_back(32'h504);
    exp_adr.push_back(32'h508);
    push_dec(I_ADDI, 32'h500, 1'b0);
    push_dec(I_ADDI, 32'h504, 1'b0);
    push_dec(I_JALR, 32'h508, 1'b0);
    flush_to(32'h500);
    k = 0;
    while (!bus.dec_valid_o && k < 20) begin
      step();
      k++;
    end
    chk("wait_dec_valid", 96'(k < 20), 96'd1);
    repeat (5) begin
      step();
      chk("stall_stable", {bus.dec_valid_o, bus.dec_pc_o, bus.dec_inst_o, bus.ic_req_o},
          {1'b1, 32'h500, I_ADDI, 1'b0});
    end
    bus.dec_ready_i = 1'b1;
    wait_drain("phase_dec_stall", 100);

    bus.rob_br_en_i    = 1'b1;
    bus.rob_br_taken_i = 1'b1;
    bus.rob_br_pc_i    = 32'h40;
    step();
    chk("train_en",  96'(bus.bp_en_o),  96'd1);
    chk("train_abr", 96'(bus.bp_abr_o), 96'd1);
    chk("train_tpc", 96'(bus.bp_tpc_o), 96'h40);
    bus.rob_br_en_i    = 1'b0;
    bus.rob_br_taken_i = 1'b0;
    step();
    chk("train_en_clear", 96'(bus.bp_en_o), 96'd0);

    // Freeze: training and redirect both ignored while en is low.
    en = 1'b0;
    bus.rob_br_en_i    = 1'b1;
    bus.rob_br_taken_i = 1'b1;
    bus.rob_br_pc_i    = 32'h80;
    bus.flush_i        = 1'b1;
    bus.flush_pc_i     = 32'h600;
    step(3);
    chk("freeze_bp_en",  96'(bus.bp_en_o),  96'd0);
    chk("freeze_bp_tpc", 96'(bus.bp_tpc_o), 96'h40);
    chk("freeze_adr",    96'(bus.ic_adr_o), 96'h508);
    chk("freeze_req",    96'(bus.ic_req_o), 96'd0);
    en = 1'b1;
    bus.rob_br_en_i = 1'b0;
    bus.flush_i     = 1'b0;
    step();

    exp_adr.push_back(32'h600);
    push_dec(I_JALR, 32'h600, 1'b0);
    flush_to(32'h600);
    wait_drain("phase_after_freeze", 100);
    check_no_req("final_no_req", 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
